teclado_captura: RTL

4x4 matrix-keypad reader that builds the 8-bit operand `N` and the `Start` strobe for the processor FSM/datapath. It replaces the switch bank as the input end of the design. The block scans the columns, debounces the rows and accumulates decimal digits. On the enter key it commits the value and pulses `Start` for one cycle. The in-progress value is exported so the display multiplexer can echo it while the user types.

---
 rtl/teclado_captura_if.sv | 28 ++
 rtl/teclado_captura.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/teclado_captura_if.sv
// Keypad-side and processor-side signals of the keypad reader.
// master = the reader itself; slave = keypad/processor/display side.
interface teclado_captura_if;
  logic [3:0] Filas;
  logic [3:0] Columnas;
  logic [7:0] N;
  logic       Start;
  logic [7:0] Entrada;
  logic       Error;

  modport master (
    input  Filas,
    output Columnas,
    output N,
    output Start,
    output Entrada,
    output Error
  );

  modport slave (
    output Filas,
    input  Columnas,
    input  N,
    input  Start,
    input  Entrada,
    input  Error
  );
endinterface

// File: rtl/teclado_captura.sv
// 4x4 matrix keypad reader: column scan, frame debounce and decimal operand entry.
// state     | meaning
// SOLTAR    | waiting for DEB_FRAMES empty frames before a new press may count
// LIBRE     | keypad released, waiting for a single-key frame
// CANDIDATA | one key seen, counting identical single-key frames
module teclado_captura #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_FRAMES = 4
) (
  input  logic Clk,
  input  logic Rst,
  teclado_captura_if.master bus
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_TC     = CW'(DEB_FRAMES);

  localparam logic [1:0] SOLTAR    = 2'd0;
  localparam logic [1:0] LIBRE     = 2'd1;
  localparam logic [1:0] CANDIDATA = 2'd2;

  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_HASH = 4'd14;

  // scan
  logic [3:0]    filas_s1;
  logic [3:0]    filas_s2;
  logic [1:0]    col;
  logic [DW-1:0] dwell;
  logic [15:0]   snap;
  logic [15:0]   frame;
  logic          dwell_last;
  logic          frame_done;

  // classification
  logic [4:0]    n_set;
  logic [3:0]    key_idx;
  logic          is_empty;
  logic          is_single;
  logic          is_multi;

  // debounce
  logic [1:0]    state;
  logic [CW-1:0] rel_cnt;
  logic [CW-1:0] cand_cnt;
  logic [CW-1:0] rel_inc;
  logic [CW-1:0] cand_inc;
  logic [3:0]    cand_key;
  logic          acc_valid;
  logic [3:0]    acc_key;

  // entry
  logic [7:0]    entrada;
  logic [7:0]    n_reg;
  logic          start;
  logic          error;
  logic          is_digit;
  logic [3:0]    digit;
  logic [11:0]   t_val;

  assign dwell_last = (dwell == '0);
  assign frame_done = dwell_last && (col == 2'd3);

  // The column being sampled this cycle is merged in so the last column of a
  // frame is classified on the same edge that stores it.
  always_comb begin
    frame = snap;
    if (dwell_last) begin
      for (int r = 0; r < 4; r++) begin
        frame[{2'(r), col}] = ~filas_s2[r];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      filas_s1 <= 4'hF;
      filas_s2 <= 4'hF;
      col      <= 2'd0;
      dwell    <= DWELL_LOAD;
      snap     <= '0;
    end else begin
      filas_s1 <= bus.Filas;
      filas_s2 <= filas_s1;
      if (dwell_last) begin
        dwell <= DWELL_LOAD;
        col   <= col + 2'd1;
        snap  <= frame;
      end else begin
        dwell <= dwell - DW'(1);
      end
    end
  end

  always_comb begin
    n_set   = '0;
    key_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        n_set   = n_set + 5'd1;
        key_idx = 4'(i);
      end
    end
  end

  assign is_empty  = (n_set == 5'd0);
  assign is_single = (n_set == 5'd1);
  assign is_multi  = (n_set > 5'd1);

  assign rel_inc  = (rel_cnt  < DEB_TC) ? rel_cnt  + CW'(1) : rel_cnt;
  assign cand_inc = (cand_cnt < DEB_TC) ? cand_cnt + CW'(1) : cand_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= SOLTAR;
      rel_cnt   <= '0;
      cand_cnt  <= '0;
      cand_key  <= '0;
      acc_valid <= 1'b0;
      acc_key   <= '0;
    end else begin
      acc_valid <= 1'b0;
      if (frame_done) begin
        case (state)
          SOLTAR: begin
            if (is_empty) begin
              if (rel_inc >= DEB_TC) begin
                state   <= LIBRE;
                rel_cnt <= '0;
              end else begin
                rel_cnt <= rel_inc;
              end
            end else begin
              rel_cnt <= '0;
            end
          end
          LIBRE: begin
            if (is_single) begin
              cand_key <= key_idx;
              if (CW'(1) >= DEB_TC) begin
                acc_valid <= 1'b1;
                acc_key   <= key_idx;
                cand_cnt  <= '0;
                state     <= SOLTAR;
              end else begin
                cand_cnt <= CW'(1);
                state    <= CANDIDATA;
              end
            end
          end
          CANDIDATA: begin
            if (is_single && key_idx == cand_key) begin
              if (cand_inc >= DEB_TC) begin
                acc_valid <= 1'b1;
                acc_key   <= cand_key;
                cand_cnt  <= '0;
                rel_cnt   <= '0;
                state     <= SOLTAR;
              end else begin
                cand_cnt <= cand_inc;
              end
            end else if (is_single) begin
              cand_key <= key_idx;
              cand_cnt <= CW'(1);
            end else if (is_multi) begin
              cand_cnt <= '0;
              rel_cnt  <= '0;
              state    <= SOLTAR;
            end else begin
              cand_cnt <= '0;
              state    <= LIBRE;
            end
          end
          default: begin
            rel_cnt  <= '0;
            cand_cnt <= '0;
            state    <= SOLTAR;
          end
        endcase
      end
    end
  end

  // Key index r*4+c -> decimal digit; letters, '*' and '#' are not digits.
  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (acc_key)
      4'd0:    digit = 4'd1;
      4'd1:    digit = 4'd2;
      4'd2:    digit = 4'd3;
      4'd4:    digit = 4'd4;
      4'd5:    digit = 4'd5;
      4'd6:    digit = 4'd6;
      4'd8:    digit = 4'd7;
      4'd9:    digit = 4'd8;
      4'd10:   digit = 4'd9;
      4'd13:   digit = 4'd0;
      default: is_digit = 1'b0;
    endcase
  end

  assign t_val = {4'b0, entrada} * 12'd10 + {8'b0, digit};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      entrada <= '0;
      n_reg   <= '0;
      start   <= 1'b0;
      error   <= 1'b0;
    end else begin
      start <= 1'b0;
      if (acc_valid) begin
        if (is_digit) begin
          if (t_val <= 12'd255) begin
            entrada <= t_val[7:0];
          end else begin
            error <= 1'b1;
          end
        end else if (acc_key == KEY_STAR) begin
          entrada <= '0;
          error   <= 1'b0;
        end else if (acc_key == KEY_HASH && !error) begin
          n_reg   <= entrada;
          start   <= 1'b1;
          entrada <= '0;
        end
      end
    end
  end

  assign bus.Columnas = ~(4'b0001 << col);
  assign bus.N        = n_reg;
  assign bus.Start    = start;
  assign bus.Entrada  = entrada;
  assign bus.Error    = error;

endmodule
